// File: rtl/tcam_pipelined.sv
// Register-based ternary/binary CAM with valid bits, insert/delete write sequence
// and a two-stage lookup returning the lowest hit index plus a multi-hit flag.
module tcam_pipelined #(
  parameter int unsigned ID                      = 0,
  parameter int unsigned ID_BITS                 = 1,
  parameter int unsigned CAM_MODE                = 1,
  parameter int unsigned C_TCAM_ADDR_WIDTH       = 5,
  parameter int unsigned C_TCAM_DATA_WIDTH       = 32,
  parameter int unsigned C_TCAM_MATCH_ADDR_WIDTH = ID_BITS + C_TCAM_ADDR_WIDTH
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               WE,
  input  logic [C_TCAM_ADDR_WIDTH-1:0]       ADDR_WR,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       DIN,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       DIN_MASK,
  input  logic                               DIN_VLD,
  output logic                               BUSY,
  input  logic                               CMP_REQ,
  input  logic [C_TCAM_DATA_WIDTH-1:0]       CMP_DIN,
  output logic                               MATCH_VLD,
  output logic                               MATCH,
  output logic                               MULTI_MATCH,
  output logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] MATCH_ADDR
);

  localparam int unsigned AW    = C_TCAM_ADDR_WIDTH;
  localparam int unsigned DW    = C_TCAM_DATA_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned IDW   = (ID_BITS == 0) ? 1 : ID_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INVAL  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic [DEPTH-1:0] r_valid;
  logic [DW-1:0]   r_key  [DEPTH];
  logic [DW-1:0]   r_mask [DEPTH];
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_key;
  logic [DW-1:0]   r_wr_mask;
  logic            r_wr_vld;

  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] r_hit;
  logic             r_s1_vld;

  logic             w_enc_any;
  logic             w_enc_multi;
  logic [AW-1:0]    w_enc_idx;

  logic             r_match_vld;
  logic             r_match;
  logic             r_multi;
  logic [AW-1:0]    r_match_idx;

  logic [DW-1:0]    w_din_mask;

  // Binary builds store an all-care mask so every key bit takes part in the compare.
  assign w_din_mask = (CAM_MODE != 0) ? DIN_MASK : '0;

  // Write sequencer: invalidate target, store key/mask, then commit the valid bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (WE) begin
            r_valid[ADDR_WR] <= 1'b0;
            r_state          <= S_INVAL;
            r_busy           <= 1'b1;
          end
        end
        S_INVAL: begin
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_valid[r_wr_addr] <= r_wr_vld;
          r_state            <= S_IDLE;
          r_busy             <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Request capture and entry storage carry no reset; validity is governed by r_valid.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && WE) begin
      r_wr_addr <= ADDR_WR;
      r_wr_key  <= DIN;
      r_wr_mask <= w_din_mask;
      r_wr_vld  <= DIN_VLD;
    end
    if (!RST && r_state == S_INVAL) begin
      r_key[r_wr_addr]  <= r_wr_key;
      r_mask[r_wr_addr] <= r_wr_mask;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign w_hit[g] = r_valid[g] && (((CMP_DIN ^ r_key[g]) & ~r_mask[g]) == '0);
  end

  // Stage 1: capture the hit vector of the current table contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= CMP_REQ;
      if (CMP_REQ) begin
        r_hit <= w_hit;
      end
    end
  end

  // Lowest-index priority encode; a second hit raises the multi-match flag.
  always_comb begin
    w_enc_any   = 1'b0;
    w_enc_multi = 1'b0;
    w_enc_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_hit[i]) begin
        if (w_enc_any) begin
          w_enc_multi = 1'b1;
        end else begin
          w_enc_idx = AW'(i);
          w_enc_any = 1'b1;
        end
      end
    end
  end

  // Stage 2: result registers update only alongside a MATCH_VLD pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_match_vld <= 1'b0;
      r_match     <= 1'b0;
      r_multi     <= 1'b0;
      r_match_idx <= '0;
    end else begin
      r_match_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_match     <= w_enc_any;
        r_multi     <= w_enc_multi;
        r_match_idx <= w_enc_idx;
      end
    end
  end

  assign BUSY        = r_busy;
  assign MATCH_VLD   = r_match_vld;
  assign MATCH       = r_match;
  assign MULTI_MATCH = r_multi;

  if (ID_BITS > 0) begin : g_id_prefix
    assign MATCH_ADDR = {IDW'(ID), r_match_idx};
  end else begin : g_no_prefix
    assign MATCH_ADDR = r_match_idx;
  end

endmodule

// File: tb/tb_tcam_pipelined.sv
// Bench for tcam_pipelined: a ternary instance with ID prefix and a binary instance
// without prefix share stimulus; lookup expectations go through a due-cycle scoreboard.
module tb_tcam_pipelined;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WE;
  logic [AW-1:0] ADDR_WR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DIN_MASK;
  logic          DIN_VLD;
  logic          CMP_REQ;
  logic [DW-1:0] CMP_DIN;

  logic          m_busy, m_vld, m_match, m_multi;
  logic [AW:0]   m_addr;
  logic          b_busy, b_vld, b_match, b_multi;
  logic [AW-1:0] b_addr;

  always #5 CLK = ~CLK;

  tcam_pipelined #(
    .ID(1), .ID_BITS(1), .CAM_MODE(1),
    .C_TCAM_ADDR_WIDTH(AW), .C_TCAM_DATA_WIDTH(DW), .C_TCAM_MATCH_ADDR_WIDTH(AW + 1)
  ) u_tern (
    .CLK(CLK), .RST(RST), .WE(WE), .ADDR_WR(ADDR_WR), .DIN(DIN), .DIN_MASK(DIN_MASK),
    .DIN_VLD(DIN_VLD), .BUSY(m_busy), .CMP_REQ(CMP_REQ), .CMP_DIN(CMP_DIN),
    .MATCH_VLD(m_vld), .MATCH(m_match), .MULTI_MATCH(m_multi), .MATCH_ADDR(m_addr)
  );

  tcam_pipelined #(
    .ID(0), .ID_BITS(0), .CAM_MODE(0),
    .C_TCAM_ADDR_WIDTH(AW), .C_TCAM_DATA_WIDTH(DW), .C_TCAM_MATCH_ADDR_WIDTH(AW)
  ) u_bin (
    .CLK(CLK), .RST(RST), .WE(WE), .ADDR_WR(ADDR_WR), .DIN(DIN), .DIN_MASK(DIN_MASK),
    .DIN_VLD(DIN_VLD), .BUSY(b_busy), .CMP_REQ(CMP_REQ), .CMP_DIN(CMP_DIN),
    .MATCH_VLD(b_vld), .MATCH(b_match), .MULTI_MATCH(b_multi), .MATCH_ADDR(b_addr)
  );

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] key;
    logic [DW-1:0] mask;
    bit            vld;
    bit            m_hit;
    bit            m_multi;
    logic [AW-1:0] m_idx;
    bit            b_hit;
    bit            b_multi;
    logic [AW-1:0] b_idx;
  } vec_t;

  typedef struct {
    int            due;
    bit            m_hit;
    bit            m_multi;
    logic [AW-1:0] m_idx;
    bit            b_hit;
    bit            b_multi;
    logic [AW-1:0] b_idx;
  } exp_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  exp_t sb [$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int vld_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: results must appear exactly on their due cycle.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (m_vld) vld_cnt++;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_result: got no MATCH_VLD expected one at cycle %0d", sb[0].due);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("tern_vld",   m_vld,   1);
      check("tern_match", m_match, e.m_hit);
      check("tern_multi", m_multi, e.m_multi);
      check("tern_addr",  m_addr,  {1'b1, e.m_idx});
      check("bin_vld",    b_vld,   1);
      check("bin_match",  b_match, e.b_hit);
      check("bin_multi",  b_multi, e.b_multi);
      check("bin_addr",   b_addr,  e.b_idx);
    end else if (m_vld || b_vld) begin
      checks++;
      errors++;
      $display("FAIL unexpected_vld: got tern=%0b bin=%0b expected 0 at cycle %0d", m_vld, b_vld, cyc);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input logic [DW-1:0] key, input bit mh, input bit mm, input logic [AW-1:0] mi,
                        input bit bh, input bit bm, input logic [AW-1:0] bi);
    exp_t e;
    CMP_REQ   = 1'b1;
    CMP_DIN   = key;
    e.due     = cyc + 2;
    e.m_hit   = mh;
    e.m_multi = mm;
    e.m_idx   = mi;
    e.b_hit   = bh;
    e.b_multi = bm;
    e.b_idx   = bi;
    sb.push_back(e);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] k, input logic [DW-1:0] m, input bit v);
    int n;
    CMP_REQ = 1'b0;
    n = 0;
    while (m_busy && n < 10) begin tick(); n++; end
    if (n == 10) check("wr_wait_timeout", m_busy, 0);
    WE = 1'b1; ADDR_WR = a; DIN = k; DIN_MASK = m; DIN_VLD = v;
    tick();
    WE = 1'b0;
    n = 0;
    while (m_busy && n < 10) begin tick(); n++; end
    if (n == 10) check("wr_done_timeout", m_busy, 0);
  endtask

  function automatic vec_t mkw(input logic [AW-1:0] a, input logic [DW-1:0] k, input logic [DW-1:0] m, input bit v);
    vec_t x;
    x = '{default: 0};
    x.is_wr = 1'b1; x.addr = a; x.key = k; x.mask = m; x.vld = v;
    return x;
  endfunction

  function automatic vec_t mkl(input logic [DW-1:0] k, input bit mh, input bit mm, input logic [AW-1:0] mi,
                               input bit bh, input bit bm, input logic [AW-1:0] bi);
    vec_t x;
    x = '{default: 0};
    x.key = k; x.m_hit = mh; x.m_multi = mm; x.m_idx = mi;
    x.b_hit = bh; x.b_multi = bm; x.b_idx = bi;
    return x;
  endfunction

  initial begin
    int n;
    int base;
    vecs[0]  = mkw(5'd3,  32'hA5A5_0001, 32'h0, 1'b1);
    vecs[1]  = mkl(32'hA5A5_0001, 1, 0, 5'd3,  1, 0, 5'd3);
    vecs[2]  = mkl(32'hA5A5_0002, 0, 0, 5'd0,  0, 0, 5'd0);
    vecs[3]  = mkw(5'd7,  32'h0A00_0000, 32'h00FF_FFFF, 1'b1);
    vecs[4]  = mkl(32'h0A12_3456, 1, 0, 5'd7,  0, 0, 5'd0);
    vecs[5]  = mkl(32'h0A00_0000, 1, 0, 5'd7,  1, 0, 5'd7);
    vecs[6]  = mkw(5'd9,  32'h1234_5678, 32'h0, 1'b1);
    vecs[7]  = mkw(5'd2,  32'h1234_5678, 32'h0, 1'b1);
    vecs[8]  = mkl(32'h1234_5678, 1, 1, 5'd2,  1, 1, 5'd2);
    vecs[9]  = mkw(5'd2,  32'h1234_5678, 32'h0, 1'b0);
    vecs[10] = mkl(32'h1234_5678, 1, 0, 5'd9,  1, 0, 5'd9);
    vecs[11] = mkw(5'd31, 32'hFFFF_FFFF, 32'h0, 1'b1);
    vecs[12] = mkl(32'hFFFF_FFFF, 1, 0, 5'd31, 1, 0, 5'd31);
    vecs[13] = mkw(5'd0,  32'h0, 32'hFFFF_FFFF, 1'b1);
    vecs[14] = mkl(32'hFFFF_FFFF, 1, 1, 5'd0,  1, 0, 5'd31);
    vecs[15] = mkw(5'd0,  32'h0, 32'hFFFF_FFFF, 1'b0);
    vecs[16] = mkl(32'h0000_0000, 0, 0, 5'd0,  0, 0, 5'd0);

    RST = 1'b1; WE = 1'b0; ADDR_WR = '0; DIN = '0; DIN_MASK = '0; DIN_VLD = 1'b0;
    CMP_REQ = 1'b0; CMP_DIN = '0;
    repeat (3) tick();
    check("rst_busy",  m_busy,  0);
    check("rst_vld",   m_vld,   0);
    check("rst_match", m_match, 0);
    check("rst_multi", m_multi, 0);
    check("rst_addr",  m_addr,  7'h20);
    check("rst_baddr", b_addr,  0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].key, vecs[i].mask, vecs[i].vld);
      end else begin
        lookup(vecs[i].key, vecs[i].m_hit, vecs[i].m_multi, vecs[i].m_idx,
               vecs[i].b_hit, vecs[i].b_multi, vecs[i].b_idx);
        tick();
        CMP_REQ = 1'b0;
      end
    end

    // WE held into the busy window: second request (idx 4) must be dropped.
    check("busy_pre", m_busy, 0);
    WE = 1'b1; ADDR_WR = 5'd5; DIN = 32'h5555_0005; DIN_MASK = '0; DIN_VLD = 1'b1;
    tick();
    check("busy_t1", m_busy, 1);
    ADDR_WR = 5'd4; DIN = 32'h4444_0004;
    tick();
    WE = 1'b0;
    check("busy_t2", m_busy, 1);
    tick();
    check("busy_t3", m_busy, 0);
    lookup(32'h4444_0004, 0, 0, 5'd0, 0, 0, 5'd0);
    tick();
    lookup(32'h5555_0005, 1, 0, 5'd5, 1, 0, 5'd5);
    tick();
    CMP_REQ = 1'b0;
    tick();

    // Overwrite idx 3 while lookups run every cycle around the write.
    WE = 1'b1; ADDR_WR = 5'd3; DIN = 32'hC0DE_0003; DIN_MASK = '0; DIN_VLD = 1'b1;
    lookup(32'hA5A5_0001, 1, 0, 5'd3, 1, 0, 5'd3);
    tick();
    WE = 1'b0;
    lookup(32'hA5A5_0001, 0, 0, 5'd0, 0, 0, 5'd0);
    tick();
    lookup(32'hC0DE_0003, 0, 0, 5'd0, 0, 0, 5'd0);
    tick();
    lookup(32'hC0DE_0003, 1, 0, 5'd3, 1, 0, 5'd3);
    tick();
    CMP_REQ = 1'b0;
    repeat (3) tick();

    // Eight back-to-back lookups produce eight consecutive results.
    base = vld_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) lookup(32'hC0DE_0003, 1, 0, 5'd3, 1, 0, 5'd3);
      else            lookup(32'h0A00_0000, 1, 0, 5'd7, 1, 0, 5'd7);
      tick();
    end
    CMP_REQ = 1'b0;
    repeat (3) tick();
    check("burst_pulses", vld_cnt - base, 8);

    // Reset while the write sequencer sits in INVAL.
    WE = 1'b1; ADDR_WR = 5'd10; DIN = 32'h0000_0055; DIN_MASK = '0; DIN_VLD = 1'b1;
    tick();
    WE = 1'b0;
    check("rstw_busy_pre", m_busy, 1);
    RST = 1'b1;
    tick();
    check("rstw_busy",   m_busy,  0);
    check("rstw_vld",    m_vld,   0);
    check("rstw_match",  m_match, 0);
    check("rstw_multi",  m_multi, 0);
    check("rstw_addr",   m_addr,  7'h20);
    check("rstw_bmatch", b_match, 0);
    check("rstw_baddr",  b_addr,  0);
    RST = 1'b0;
    tick();
    lookup(32'hC0DE_0003, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    lookup(32'h0A12_3456, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    lookup(32'h1234_5678, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    lookup(32'hFFFF_FFFF, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    lookup(32'h5555_0005, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    lookup(32'h0000_0055, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    CMP_REQ = 1'b0;

    n = 0;
    while (sb.size() > 0 && n < 20) begin tick(); n++; end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcam_pipelined.md
Name: tcam_pipelined

Overview:
Parametrised ternary/binary CAM with per-entry valid bits, insert/delete writes and a two-stage pipelined lookup. Each lookup returns the lowest matching index, a multi-match flag and an ID-prefixed match address. It sits between the header parser and the output port lookup, and supersedes the single-cycle CAM wrapper for tables needing masks, deletes and higher clock rates. The entry store is registers, so no vendor CAM primitive is required.

Parameters:
ID, 0, table identifier prepended to MATCH_ADDR
ID_BITS, 1, width of the ID prefix; 0 means no prefix
CAM_MODE, 1, 1 = ternary (DIN_MASK honoured); 0 = binary (masks forced to 0)
C_TCAM_ADDR_WIDTH, 5, entry index width; depth = 2**C_TCAM_ADDR_WIDTH
C_TCAM_DATA_WIDTH, 32, key width
C_TCAM_MATCH_ADDR_WIDTH, ID_BITS+C_TCAM_ADDR_WIDTH, MATCH_ADDR width; must equal that sum

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
WE  in  1  write request, accepted only when BUSY=0
ADDR_WR  in  C_TCAM_ADDR_WIDTH  entry index to write
DIN  in  C_TCAM_DATA_WIDTH  entry key
DIN_MASK  in  C_TCAM_DATA_WIDTH  don't-care bits (1 = ignore bit); ignored when CAM_MODE=0
DIN_VLD  in  1  1 = install entry; 0 = delete entry
BUSY  out  1  write sequence in progress
CMP_REQ  in  1  lookup request; one lookup per cycle, never stalled
CMP_DIN  in  C_TCAM_DATA_WIDTH  lookup key
MATCH_VLD  out  1  one-cycle pulse: result valid
MATCH  out  1  at least one entry hit
MULTI_MATCH  out  1  two or more entries hit
MATCH_ADDR  out  C_TCAM_MATCH_ADDR_WIDTH  {ID, lowest hit index}

Behaviour:
- Reset: all valid bits = 0, write FSM = IDLE, BUSY = 0, MATCH_VLD/MATCH/MULTI_MATCH = 0, MATCH_ADDR index field = 0, pipeline stage valids = 0. Key and mask storage are not reset.
- Reset mid-write aborts the sequence. The target entry ends invalid, as do all other entries.
- Write FSM states: IDLE -> INVAL -> COMMIT -> IDLE.
  - Edge T, IDLE with WE=1: latch ADDR_WR/DIN/DIN_MASK/DIN_VLD, clear valid[ADDR_WR], go to INVAL.
  - Edge T+1: write key and mask (mask forced 0 if CAM_MODE=0), go to COMMIT.
  - Edge T+2: valid[addr] <= latched DIN_VLD, go to IDLE.
- BUSY = 1 in INVAL and COMMIT, i.e. two cycles per write. The earliest next write is accepted at edge T+3.
- WE while BUSY=1 is ignored with no side effect. The producer holds WE until it sees BUSY=0.
- Delete (DIN_VLD=0) runs the same 3-state sequence; the entry stays invalid.
- Hit rule for entry i: valid[i] AND ((CMP_DIN XOR key[i]) AND NOT mask[i]) == 0.
- Lookup pipeline, latency 2:
  - Edge T with CMP_REQ=1: register the hit vector computed from the table contents visible during cycle T.
  - Edge T+1: priority-encode the hit vector (lowest index wins), compute the popcount-ge-2 flag, register the outputs, and MATCH_VLD = 1 during cycle T+2.
- Back-to-back CMP_REQ yields back-to-back MATCH_VLD.
- MATCH, MULTI_MATCH and MATCH_ADDR update only when MATCH_VLD is produced and hold otherwise.
- No hit: MATCH=0, MULTI_MATCH=0, MATCH_ADDR = {ID, 0}.
- Write/lookup ordering:
  - A lookup issued in the same cycle as WE acceptance sees the pre-write entry.
  - Lookups issued while BUSY=1 see the target entry as invalid.
  - Lookups issued from cycle T+3 onward see the new entry.
  - All other entries are unaffected throughout.
- ID_BITS=0: MATCH_ADDR equals the index only.
- Indices wrap naturally: ADDR_WR is full-range and all 2**C_TCAM_ADDR_WIDTH entries are usable.

Test Plan:
- Install idx 3 key 0xA5A5_0001 mask 0; wait for BUSY low; lookup 0xA5A5_0001 -> MATCH_VLD 2 cycles after CMP_REQ, MATCH=1, MULTI=0, MATCH_ADDR={ID,5'd3}; lookup 0xA5A5_0002 -> MATCH=0, addr index 0.
- Ternary: idx 7 key 0x0A000000 mask 0x00FFFFFF; lookup 0x0A123456 -> hit idx 7. CAM_MODE=0 build, same stimulus -> no hit.
- Priority: identical key at idx 9 and idx 2 -> MATCH_ADDR index 2, MULTI_MATCH=1. Delete idx 2 -> index 9, MULTI=0.
- Busy: WE at cycle T and again at T+1 with idx 4 -> the second write is ignored (idx 4 stays invalid). BUSY high exactly in cycles T+1 and T+2.
- Coherency: overwrite idx 3 with a new key; lookup the old key at T (hit), at T+1 (miss), and the new key at T+3 (hit). CMP_REQ held high for 8 cycles -> 8 consecutive MATCH_VLD pulses.
- RST asserted during INVAL -> BUSY=0 and outputs 0 the next cycle. Every previously installed key then misses.
